mx_mac_seq: RTL
===============

Name: mx_mac_seq

Overview:
- Job sequencer for one MX_MAC accumulator.
- Accepts a dot-product command of N operand blocks, clears the MAC accumulator, and gates N operand beats into the MAC. After the MAC's 1-cycle accumulate latency it captures the final mantissa/exponent/sign and returns it over a valid/ready result port.
- Sits between the operand-fetch logic and the MX_MAC instance. The operand data itself is not carried; only the handshake, gating, mode and shared-exponent routing pass through this block.

Parameters:
- M_out_width, 23, MAC mantissa output width.
- LEN_W, 8, width of the block-count field.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- cmd_valid_i  in  1  job request
- cmd_ready_o  out  1  job accepted when both high
- cmd_len_i  in  LEN_W  number of operand blocks (0 allowed)
- cmd_prec_mode_i  in  2  0=8b, 1=4b, 2=2b
- cmd_fp_mode_i  in  2  FP mode for the job
- op_valid_i  in  1  operand beat present at MAC inputs
- op_ready_o  out  1  beat consumed when both high
- shared_exps0_i  in  8  A-block shared exponent of the current beat
- shared_exps1_i  in  8  B-block shared exponent of the current beat
- mac_rstn_o  out  1  MAC accumulator reset, active low, registered
- mac_zero_o  out  1  datapath forces MAC mantissas and signs to 0
- mac_prec_mode_o  out  2  latched prec_mode
- mac_fp_mode_o  out  2  latched FP_mode
- mac_shared_exps0_o  out  8  to MAC shared_exps0
- mac_shared_exps1_o  out  8  to MAC shared_exps1
- mac_mant_i  in  M_out_width  MAC_mant_out
- mac_exp_i  in  8  MAC_exp_out
- mac_sign_i  in  1  MAC_sign_out
- res_valid_o  out  1  result available
- res_ready_i  in  1  result consumed
- res_mant_o  out  M_out_width  captured mantissa
- res_exp_o  out  8  captured exponent
- res_sign_o  out  1  captured sign
- busy_o  out  1  state != IDLE
- blk_cnt_o  out  LEN_W  beats accepted in the current job

Behaviour:
- **States:** IDLE, CLEAR, RUN, DRAIN, DONE.
- **Reset (rst_i=1 at posedge):**
  - state=IDLE, mac_rstn_o=0, and every other registered output = 0.
  - mac_zero_o=1 and cmd_ready_o=1 from the first cycle after reset.
  - A reset mid-job abandons the job: no result is produced, and the accumulator is cleared via mac_rstn_o.
- **IDLE:**
  - cmd_ready_o=1, mac_rstn_o=1.
  - On cmd_valid_i: latch len/prec/fp, clear blk_cnt_o to 0, set mac_rstn_o=0 (registered) and go to CLEAR.
- **CLEAR (1 cycle):**
  - mac_rstn_o=0; the accumulator is cleared asynchronously inside the MAC.
  - Next state is RUN if len!=0, else DRAIN. mac_rstn_o returns to 1 at that edge.
- **RUN:**
  - op_ready_o=1.
  - mac_zero_o = ~(op_valid_i & op_ready_o), combinational.
  - Each accepted beat increments blk_cnt_o.
  - When the beat making blk_cnt == len is accepted, the next state is DRAIN. Exactly len beats are accepted; op_ready_o=0 in all other states.
  - Bubbles (op_valid_i=0) are allowed; the MAC adds +0 during a bubble.
- **Shared-exponent routing:**
  - mac_shared_exps0_o and mac_shared_exps1_o pass shared_exps*_i through only when a beat is accepted.
  - Otherwise both are forced to 8'd127, so zero products add no exponent bias.
- **DRAIN (1 cycle):**
  - mac_zero_o=1. The accumulator now holds the sum of all beats.
  - Register mac_mant_i, mac_exp_i, mac_sign_i into res_*_o, set res_valid_o=1 and go to DONE.
- **DONE:**
  - res_valid_o and res_* are held stable until res_ready_i=1.
  - On that cycle's edge: res_valid_o=0 and go to IDLE.
  - cmd_ready_o=0 throughout DONE; a new command can only be accepted from IDLE, one cycle after the result is consumed.
- **Latency:**
  - Command accept at cycle 0 → first beat acceptable in cycle 2.
  - With the last beat accepted in cycle t, res_valid_o rises at cycle t+2.
- **len=0:** result = cleared accumulator (mant=0, exp=0, sign=0); res_valid_o rises at cycle 3.
- **Outputs:**
  - mac_prec_mode_o and mac_fp_mode_o hold the latched job values until the next accept.
  - busy_o=1 from CLEAR through DONE.
- **blk_cnt_o:** holds its final value until the next command accept; no wrap, since the maximum is len ≤ 2^LEN_W−1.
- **Simultaneous events:**
  - cmd_valid_i outside IDLE is ignored.
  - op_valid_i outside RUN is not acknowledged.

Test Plan:
- Reset with rst_i=1 during RUN after 3 of 5 beats → next cycle state IDLE, mac_rstn_o=0, op_ready_o=0, res_valid_o=0; after release, cmd_ready_o=1 and no result appears.
- cmd_len=4, op_valid_i held 1, res_ready_i=1 → exactly 4 op handshakes in cycles 2–5, res_valid_o high at cycle 7, res_* equals mac_*_i sampled at cycle 6, blk_cnt_o=4.
- cmd_len=3 with op_valid_i toggling 1,0,1,0,1 → 3 handshakes; mac_zero_o=1 and mac_shared_exps*_o=127 in bubble cycles; pass-through values on accepted beats.
- cmd_len=0 → CLEAR then DRAIN; res_valid_o at cycle 3 with res_mant_o=0, res_exp_o=0, res_sign_o=0; no op_ready_o pulse.
- Result backpressure: res_ready_i=0 for 5 cycles → res_* stable, cmd_ready_o=0, a cmd_valid_i pulse is ignored; res_ready_i=1 → IDLE next cycle, then a new command is accepted.
- prec_mode=1, FP_mode=2 latched at accept while cmd_* inputs change mid-job → mac_prec_mode_o=1 and mac_fp_mode_o=2 for the whole job.

Source files
------------

// File: rtl/mx_mac_seq.sv
// ---------------------------------------------------------------------------
// mx_mac_seq
//
// Job sequencer for a single MX_MAC accumulator. A command names how many
// operand blocks make up one dot product. The sequencer clears the MAC
// accumulator, lets exactly that many operand beats through to the MAC,
// waits for the MAC's one-cycle accumulate latency, and then captures the
// accumulated mantissa/exponent/sign. The captured value is returned on a
// valid/ready result port.
//
// Operand data never passes through this block. Only the handshakes, the
// beat gating (mac_zero_o), the job modes and the shared-exponent routing do.
//
// Ports
//   clk_i, rst_i               clock, synchronous active-high reset
//   cmd_valid_i/cmd_ready_o    job request handshake
//   cmd_len_i                  number of operand blocks (0 allowed)
//   cmd_prec_mode_i            0=8b, 1=4b, 2=2b
//   cmd_fp_mode_i              FP mode for the job
//   op_valid_i/op_ready_o      operand beat handshake at the MAC inputs
//   shared_exps0_i/1_i         A/B shared exponents of the current beat
//   mac_rstn_o                 registered, active-low accumulator clear
//   mac_zero_o                 forces MAC mantissas/signs to zero
//   mac_prec_mode_o/fp_mode_o  job modes latched at command accept
//   mac_shared_exps0_o/1_o     shared exponents routed to the MAC
//   mac_mant_i/exp_i/sign_i    MAC accumulator outputs
//   res_valid_o/res_ready_i    result handshake
//   res_mant_o/exp_o/sign_o    captured result
//   busy_o                     high whenever a job is in flight
//   blk_cnt_o                  beats accepted in the current job
// ---------------------------------------------------------------------------
module mx_mac_seq #(
    parameter int M_out_width = 23,
    parameter int LEN_W       = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_i,

    input  logic                   cmd_valid_i,
    output logic                   cmd_ready_o,
    input  logic [LEN_W-1:0]       cmd_len_i,
    input  logic [1:0]             cmd_prec_mode_i,
    input  logic [1:0]             cmd_fp_mode_i,

    input  logic                   op_valid_i,
    output logic                   op_ready_o,
    input  logic [7:0]             shared_exps0_i,
    input  logic [7:0]             shared_exps1_i,

    output logic                   mac_rstn_o,
    output logic                   mac_zero_o,
    output logic [1:0]             mac_prec_mode_o,
    output logic [1:0]             mac_fp_mode_o,
    output logic [7:0]             mac_shared_exps0_o,
    output logic [7:0]             mac_shared_exps1_o,
    input  logic [M_out_width-1:0] mac_mant_i,
    input  logic [7:0]             mac_exp_i,
    input  logic                   mac_sign_i,

    output logic                   res_valid_o,
    input  logic                   res_ready_i,
    output logic [M_out_width-1:0] res_mant_o,
    output logic [7:0]             res_exp_o,
    output logic                   res_sign_o,

    output logic                   busy_o,
    output logic [LEN_W-1:0]       blk_cnt_o
);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        RUN,
        DRAIN,
        DONE
    } state_e;

    // An unaccepted beat still reaches the MAC as a zero product. Using an
    // exponent of 127 makes that product add no exponent bias.
    localparam logic [7:0] NeutralExp = 8'd127;

    state_e                 state_q, state_d;
    logic [LEN_W-1:0]       len_q, len_d;
    logic [LEN_W-1:0]       blkCnt_q, blkCnt_d;
    logic [1:0]             prec_q, prec_d;
    logic [1:0]             fp_q, fp_d;
    logic                   macRstn_q, macRstn_d;
    logic                   resValid_q, resValid_d;
    logic [M_out_width-1:0] resMant_q, resMant_d;
    logic [7:0]             resExp_q, resExp_d;
    logic                   resSign_q, resSign_d;

    logic                   beatAccept;
    logic [LEN_W-1:0]       blkCntInc;

    // A beat is consumed only while RUN offers ready. RUN is left on the
    // beat that reaches len, so at most len beats are ever taken.
    assign beatAccept = (state_q == RUN) && op_valid_i;
    assign blkCntInc  = blkCnt_q + LEN_W'(1);

    // Next-state and next-output logic for the job sequence. The
    // accumulator clear is requested one cycle early, so the registered
    // mac_rstn_o is low exactly during CLEAR. The result is captured in DRAIN,
    // which is the first cycle in which the MAC output includes the last beat.
    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        blkCnt_d   = blkCnt_q;
        prec_d     = prec_q;
        fp_d       = fp_q;
        macRstn_d  = 1'b1;
        resValid_d = resValid_q;
        resMant_d  = resMant_q;
        resExp_d   = resExp_q;
        resSign_d  = resSign_q;

        case (state_q)
            IDLE: begin
                if (cmd_valid_i) begin
                    len_d     = cmd_len_i;
                    prec_d    = cmd_prec_mode_i;
                    fp_d      = cmd_fp_mode_i;
                    blkCnt_d  = '0;
                    macRstn_d = 1'b0;
                    state_d   = CLEAR;
                end
            end
            CLEAR: begin
                state_d = (len_q != '0) ? RUN : DRAIN;
            end
            RUN: begin
                if (beatAccept) begin
                    blkCnt_d = blkCntInc;
                    if (blkCntInc == len_q) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                resMant_d  = mac_mant_i;
                resExp_d   = mac_exp_i;
                resSign_d  = mac_sign_i;
                resValid_d = 1'b1;
                state_d    = DONE;
            end
            DONE: begin
                if (res_ready_i) begin
                    resValid_d = 1'b0;
                    state_d    = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs. A reset abandons any job in flight.
    // It also drops mac_rstn_o, so the MAC accumulator is cleared as well.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            len_q      <= '0;
            blkCnt_q   <= '0;
            prec_q     <= '0;
            fp_q       <= '0;
            macRstn_q  <= 1'b0;
            resValid_q <= 1'b0;
            resMant_q  <= '0;
            resExp_q   <= '0;
            resSign_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            blkCnt_q   <= blkCnt_d;
            prec_q     <= prec_d;
            fp_q       <= fp_d;
            macRstn_q  <= macRstn_d;
            resValid_q <= resValid_d;
            resMant_q  <= resMant_d;
            resExp_q   <= resExp_d;
            resSign_q  <= resSign_d;
        end
    end

    assign cmd_ready_o        = (state_q == IDLE);
    assign op_ready_o         = (state_q == RUN);
    assign busy_o             = (state_q != IDLE);
    assign mac_zero_o         = ~beatAccept;
    assign mac_shared_exps0_o = beatAccept ? shared_exps0_i : NeutralExp;
    assign mac_shared_exps1_o = beatAccept ? shared_exps1_i : NeutralExp;

    assign mac_rstn_o      = macRstn_q;
    assign mac_prec_mode_o = prec_q;
    assign mac_fp_mode_o   = fp_q;
    assign res_valid_o     = resValid_q;
    assign res_mant_o      = resMant_q;
    assign res_exp_o       = resExp_q;
    assign res_sign_o      = resSign_q;
    assign blk_cnt_o       = blkCnt_q;

endmodule
